opc7_bus_responder: RTL
=======================

// Module: opc7_bus_responder
// PURPOSE
//  Bus responder for the opc7 CPU bus: the target side of the CPU's vpa/vda/vio/rnw/address/dout initiator.
//  Serves instruction fetches and data accesses from an on-chip word RAM.
//  Serves IN/OUT accesses from a small IO register bank: countdown timer, IRQ status, scratch.
//  Inserts wait states by driving clken, and drives int_b back to the CPU.
// PARAMETERS
//  MEM_AW    12  RAM address width in 32-bit words; RAM occupies word addresses 0..2^MEM_AW-1
//  MEM_WAIT  1   wait cycles (clken low) per RAM access, 0..15
//  IO_WAIT   2   wait cycles (clken low) per IO access, 0..15
// PORTS
//  clk      in   1   system clock; all state updates on the rising edge
//  reset    in   1   synchronous, active-high reset
//  address  in   20  word address from the CPU
//  wdata    in   32  CPU write data (CPU dout)
//  rnw      in   1   1 = read, 0 = write
//  vpa      in   1   instruction/operand fetch (memory space)
//  vda      in   1   data access (memory space)
//  vio      in   1   IO access (IO space)
//  rdata    out  32  read data to the CPU din; combinational
//  clken    out  1   CPU clock enable; low = wait state
//  int_b    out  2   active-low interrupt requests; int_b[1] has priority at the CPU
// BEHAVIOUR
//  Access detection
//   - access = vpa|vda|vio. Memory space = vpa|vda; IO space = vio.
//   - vio takes precedence if asserted together with vpa/vda.
//  Wait-state counter (wcnt, 4 bits); W = IO_WAIT for IO, else MEM_WAIT
//   - clken = reset | !access | (wcnt==W).
//   - If access && wcnt!=W: wcnt increments. If clken is high: wcnt <= 0.
//   - Each access therefore holds clken low for exactly W cycles, then high for 1 completing cycle.
//   - Back-to-back accesses restart from 0; there are no idle cycles between them.
//   - clken is forced high during reset so the CPU's clken-gated reset synchronisers can advance.
//  Memory
//   - Asynchronous (distributed) read: rdata = mem[address[MEM_AW-1:0]] when address < 2^MEM_AW.
//   - Reads at address >= 2^MEM_AW return 0; writes there are ignored.
//   - Write occurs only on the completing cycle (clken & vda & !rnw). One write per access.
//   - RAM contents are not affected by reset.
//  IO registers, decoded on address[3:0]; upper bits ignored
//   0 CTRL     rw  [0] timer enable, [1] timer IRQ enable, [2] auto-reload; other bits read 0
//   1 LOAD     rw  32-bit reload value
//   2 COUNT    rw  current count; a write loads COUNT directly
//   3 STATUS   r/w1c  [0] timer IRQ pending, [1] software IRQ pending
//   4 SWSET    w   write 1 to bit 1 sets STATUS[1]; reads 0
//   5 SCRATCH  rw  32-bit scratch
//   6..15      read 0, writes ignored
//   - IO writes take effect only on the completing cycle. IO read data is combinational from the registers.
//  Timer (free-running on clk, independent of clken)
//   - CTRL[0]=1 and COUNT!=0: COUNT decrements by 1 per cycle.
//   - CTRL[0]=1 and COUNT==0: set STATUS[0]. Then COUNT <= LOAD if CTRL[2]; else CTRL[0] <= 0.
//   - A COUNT write in the same cycle as a decrement/reload: the write wins.
//   - A CTRL write in the same cycle as the auto-clear of CTRL[0]: the write wins.
//  Interrupts
//   - int_b[0] = ~(STATUS[0] & CTRL[1]); int_b[1] = ~STATUS[1]. Registered-state driven, glitch-free.
//   - STATUS set event and W1C clear of the same bit in the same cycle: the set wins (bit stays 1).
//  Reset values
//   - clken=1, int_b=2'b11, wcnt=0; CTRL, LOAD, COUNT, STATUS, SCRATCH all 0.
//   - rdata follows its combinational definition.
//   - Reset asserted mid-access aborts the access: no write, wcnt=0.
// TESTING
//  1 MEM_WAIT=1, vpa=1, addr=0x010, mem[0x10]=0xDEADBEEF -> clken low 1 cycle then high; rdata=0xDEADBEEF.
//  2 vda=1, rnw=0, addr=0x020, wdata=0x12345678, then read back -> one write on the completing cycle; read returns 0x12345678.
//  3 IO_WAIT=2 -> every vio access holds clken low exactly 2 cycles; read at addr 0x00009 returns 0.
//  4 LOAD=3, COUNT=3, CTRL=0x7 -> STATUS[0] sets 4 cycles after enable; int_b=2'b10; COUNT reloads to 3; repeats every 4 cycles.
//  5 Write STATUS=1 on the same cycle the timer expires -> STATUS[0] stays 1; a later W1C with no expiry clears it; int_b[0] returns to 1.
//  6 SWSET=2 -> int_b[1]=0. Reset asserted mid-RAM-write -> RAM unchanged, clken=1, int_b=2'b11, all registers 0.

Source files
------------

// File: rtl/opc7_bus_responder.sv
// Target side of the opc7 CPU bus: word RAM for memory space, a small timer/IRQ
// register bank for IO space, wait-state insertion via clken, and active-low IRQs.
module opc7_bus_responder #(
  parameter int MEM_AW   = 12,
  parameter int MEM_WAIT = 1,
  parameter int IO_WAIT  = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [19:0] address,
  input  logic [31:0] wdata,
  input  logic        rnw,
  input  logic        vpa,
  input  logic        vda,
  input  logic        vio,
  output logic [31:0] rdata,
  output logic        clken,
  output logic [1:0]  int_b
);

  localparam int         MEM_DEPTH = 1 << MEM_AW;
  localparam logic [3:0] MEM_W     = 4'(MEM_WAIT);
  localparam logic [3:0] IO_W      = 4'(IO_WAIT);

  localparam logic [3:0] REG_CTRL    = 4'd0;
  localparam logic [3:0] REG_LOAD    = 4'd1;
  localparam logic [3:0] REG_COUNT   = 4'd2;
  localparam logic [3:0] REG_STATUS  = 4'd3;
  localparam logic [3:0] REG_SWSET   = 4'd4;
  localparam logic [3:0] REG_SCRATCH = 4'd5;

  // Handshake: the CPU holds vpa/vda/vio, rnw, address and wdata stable for the
  // whole access; the access completes on the rising edge where clken is high.

  // ---------------------------------------------------------------------------
  // Wait-state counter
  // ---------------------------------------------------------------------------
  logic       access;
  logic [3:0] wait_tgt;
  logic       wait_met;
  logic       done;
  logic [3:0] wcnt_q, wcnt_d;

  assign access   = vpa | vda | vio;
  assign wait_tgt = vio ? IO_W : MEM_W;
  assign wait_met = (wcnt_q == wait_tgt);
  assign clken    = reset | ~access | wait_met;
  // The completing cycle of an access; reset aborts any pending write.
  assign done     = access & wait_met & ~reset;

  always_comb begin
    wcnt_d = wcnt_q;
    if (clken) wcnt_d = 4'd0;
    else       wcnt_d = wcnt_q + 4'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) wcnt_q <= 4'd0;
    else       wcnt_q <= wcnt_d;
  end

  // ---------------------------------------------------------------------------
  // Word RAM (asynchronous read, no reset)
  // ---------------------------------------------------------------------------
  logic [31:0]       mem_q [0:MEM_DEPTH-1];
  logic              mem_hit;
  logic [MEM_AW-1:0] mem_idx;
  logic              mem_we;
  logic [31:0]       mem_rdata;

  assign mem_hit   = ((address >> MEM_AW) == 20'd0);
  assign mem_idx   = address[MEM_AW-1:0];
  assign mem_we    = done & ~vio & vda & ~rnw & mem_hit;
  assign mem_rdata = mem_hit ? mem_q[mem_idx] : 32'd0;

  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_idx] <= wdata;
  end

  // ---------------------------------------------------------------------------
  // IO register bank and countdown timer
  // ---------------------------------------------------------------------------
  logic [2:0]  ctrl_q, ctrl_d;
  logic [31:0] load_q, load_d;
  logic [31:0] count_q, count_d;
  logic [1:0]  status_q, status_d;
  logic [31:0] scratch_q, scratch_d;

  logic [3:0]  io_sel;
  logic        io_we;
  logic        expire;
  logic [1:0]  status_set;
  logic [1:0]  status_clr;

  assign io_sel = address[3:0];
  assign io_we  = done & vio & ~rnw;
  assign expire = ctrl_q[0] & (count_q == 32'd0);

  assign status_set = {io_we & (io_sel == REG_SWSET) & wdata[1], expire};
  assign status_clr = (io_we && io_sel == REG_STATUS) ? wdata[1:0] : 2'b00;

  always_comb begin
    ctrl_d    = ctrl_q;
    load_d    = load_q;
    count_d   = count_q;
    scratch_d = scratch_q;

    if (ctrl_q[0]) begin
      if (count_q != 32'd0) count_d   = count_q - 32'd1;
      else if (ctrl_q[2])   count_d   = load_q;
      else                  ctrl_d[0] = 1'b0;
    end

    // Bus writes land after the timer update so they win any same-cycle clash.
    if (io_we) begin
      case (io_sel)
        REG_CTRL:    ctrl_d    = wdata[2:0];
        REG_LOAD:    load_d    = wdata;
        REG_COUNT:   count_d   = wdata;
        REG_SCRATCH: scratch_d = wdata;
        default:     ;
      endcase
    end

    // A set event beats a W1C clear of the same bit.
    status_d = (status_q & ~status_clr) | status_set;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_q    <= 3'd0;
      load_q    <= 32'd0;
      count_q   <= 32'd0;
      status_q  <= 2'd0;
      scratch_q <= 32'd0;
    end else begin
      ctrl_q    <= ctrl_d;
      load_q    <= load_d;
      count_q   <= count_d;
      status_q  <= status_d;
      scratch_q <= scratch_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Read data and interrupts
  // ---------------------------------------------------------------------------
  logic [31:0] io_rdata;

  always_comb begin
    io_rdata = 32'd0;
    case (io_sel)
      REG_CTRL:    io_rdata = {29'd0, ctrl_q};
      REG_LOAD:    io_rdata = load_q;
      REG_COUNT:   io_rdata = count_q;
      REG_STATUS:  io_rdata = {30'd0, status_q};
      REG_SCRATCH: io_rdata = scratch_q;
      default:     io_rdata = 32'd0;
    endcase
  end

  assign rdata = vio ? io_rdata : mem_rdata;
  assign int_b = {~status_q[1], ~(status_q[0] & ctrl_q[1])};

endmodule
